// File: rtl/mem_writeback_stage.sv
// Memory-access / write-back stage: issues one load or store per instruction,
// waits for MFC with a bounded timeout, then drives the register-file write port.
module mem_writeback_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit R0_PROTECT     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stage_valid,
    output logic        stage_ready,
    input  logic [1:0]  op,
    input  logic [31:0] RZ,
    input  logic [31:0] RM,
    input  logic [31:0] PC_Temp,
    input  logic [4:0]  Rdst_in,
    input  logic        wr_en_in,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_DATAOUT,
    input  logic [31:0] MEM_DATAIN,
    input  logic        MFC,
    output logic [31:0] RY,
    output logic [4:0]  MuxC_Out_Rdst,
    output logic        RF_WRITE,
    output logic        MEM_ERR,
    input  logic        err_clr
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_WB} state_t;

    state_t      r_state, w_state;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_rd, w_rd, r_wr, w_wr, r_rfw, w_rfw, r_err, w_err;
    logic        r_is_load, w_is_load, r_wb_en, w_wb_en;
    logic [31:0] r_addr, w_addr, r_dout, w_dout, r_ry, w_ry;
    logic [4:0]  r_rdst, w_rdst;
    logic        w_wb_en_in;

    // Write permission is resolved at capture so WB only has to replay it.
    assign w_wb_en_in = wr_en_in && !(R0_PROTECT && (Rdst_in == 5'd0));

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_rd      = r_rd;
        w_wr      = r_wr;
        w_addr    = r_addr;
        w_dout    = r_dout;
        w_ry      = r_ry;
        w_rdst    = r_rdst;
        w_is_load = r_is_load;
        w_wb_en   = r_wb_en;
        w_rfw     = 1'b0;
        w_err     = r_err & ~err_clr;
        case (r_state)
            S_IDLE: begin
                if (stage_valid) begin
                    w_rdst    = Rdst_in;
                    w_wb_en   = w_wb_en_in;
                    w_is_load = (op == 2'b01);
                    w_cnt     = 8'd0;
                    case (op)
                        2'b00: begin w_ry = RZ;      w_rfw = w_wb_en_in; w_state = S_WB; end
                        2'b11: begin w_ry = PC_Temp; w_rfw = w_wb_en_in; w_state = S_WB; end
                        2'b01: begin w_rd = 1'b1; w_addr = RZ; w_state = S_MEM_WAIT; end
                        default: begin
                            w_wr    = 1'b1;
                            w_addr  = RZ;
                            w_dout  = RM;
                            w_state = S_MEM_WAIT;
                        end
                    endcase
                end
            end
            S_MEM_WAIT: begin
                // MFC wins over a timeout landing on the same edge.
                if (MFC) begin
                    w_rd = 1'b0;
                    w_wr = 1'b0;
                    if (r_is_load) begin
                        w_ry    = MEM_DATAIN;
                        w_rfw   = r_wb_en;
                        w_state = S_WB;
                    end else begin
                        w_state = S_IDLE;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_rd    = 1'b0;
                    w_wr    = 1'b0;
                    w_err   = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            S_WB:    w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= 32'd0;
            r_dout    <= 32'd0;
            r_ry      <= 32'd0;
            r_rdst    <= 5'd0;
            r_is_load <= 1'b0;
            r_wb_en   <= 1'b0;
            r_rfw     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_rd      <= w_rd;
            r_wr      <= w_wr;
            r_addr    <= w_addr;
            r_dout    <= w_dout;
            r_ry      <= w_ry;
            r_rdst    <= w_rdst;
            r_is_load <= w_is_load;
            r_wb_en   <= w_wb_en;
            r_rfw     <= w_rfw;
            r_err     <= w_err;
        end
    end

    assign stage_ready   = (r_state == S_IDLE);
    assign MEM_READ      = r_rd;
    assign MEM_WRITE     = r_wr;
    assign MEM_ADDR      = r_addr;
    assign MEM_DATAOUT   = r_dout;
    assign RY            = r_ry;
    assign MuxC_Out_Rdst = r_rdst;
    assign RF_WRITE      = r_rfw;
    assign MEM_ERR       = r_err;
endmodule

// File: tb/tb_mem_writeback_stage.sv
// Bench for mem_writeback_stage: per-instruction timeline model checked every cycle,
// plus literal expectations on the directed vectors.
module tb_mem_writeback_stage;
    localparam int TO = 16;

    logic        clk = 1'b0, reset_n = 1'b0, stage_valid = 1'b0, wr_en_in = 1'b0;
    logic        MFC = 1'b0, err_clr = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] RZ = '0, RM = '0, PC_Temp = '0, MEM_DATAIN = '0;
    logic [4:0]  Rdst_in = '0;
    logic        stage_ready, MEM_READ, MEM_WRITE, RF_WRITE, MEM_ERR;
    logic [31:0] MEM_ADDR, MEM_DATAOUT, RY;
    logic [4:0]  MuxC_Out_Rdst;

    mem_writeback_stage #(.TIMEOUT_CYCLES(TO), .R0_PROTECT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .stage_valid(stage_valid), .stage_ready(stage_ready),
        .op(op), .RZ(RZ), .RM(RM), .PC_Temp(PC_Temp), .Rdst_in(Rdst_in), .wr_en_in(wr_en_in),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_DATAOUT(MEM_DATAOUT), .MEM_DATAIN(MEM_DATAIN), .MFC(MFC), .RY(RY),
        .MuxC_Out_Rdst(MuxC_Out_Rdst), .RF_WRITE(RF_WRITE), .MEM_ERR(MEM_ERR),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, rfw, err, rdy;
        logic [31:0] addr, dout, ry;
        logic [4:0]  rdst;
    } snap_t;

    snap_t m;            // what the outputs must be after the next edge
    snap_t e;
    snap_t exp_a[int];   // expected outputs keyed by cycle number
    int cyc = 0, errors = 0, checks = 0;
    int rd_hi = 0, wr_hi = 0, rfw_hi = 0;
    int b_rd, b_wr, b_rfw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (MEM_READ === 1'b1)  rd_hi++;
        if (MEM_WRITE === 1'b1) wr_hi++;
        if (RF_WRITE === 1'b1)  rfw_hi++;
        if (exp_a.exists(cyc)) begin
            e = exp_a[cyc];
            chk("MEM_READ",      32'(MEM_READ),      32'(e.rd));
            chk("MEM_WRITE",     32'(MEM_WRITE),     32'(e.wr));
            chk("MEM_ADDR",      MEM_ADDR,           e.addr);
            chk("MEM_DATAOUT",   MEM_DATAOUT,        e.dout);
            chk("RY",            RY,                 e.ry);
            chk("MuxC_Out_Rdst", 32'(MuxC_Out_Rdst), 32'(e.rdst));
            chk("RF_WRITE",      32'(RF_WRITE),      32'(e.rfw));
            chk("MEM_ERR",       32'(MEM_ERR),       32'(e.err));
            chk("stage_ready",   32'(stage_ready),   32'(e.rdy));
            exp_a.delete(cyc);
        end
    end

    task automatic m_reset();
        m.rd = 0; m.wr = 0; m.rfw = 0; m.err = 0; m.rdy = 1;
        m.addr = 0; m.dout = 0; m.ry = 0; m.rdst = 0;
    endtask

    task automatic tick();
        exp_a[cyc + 1] = m;
        @(posedge clk);
        #1;
    endtask

    task automatic base();
        b_rd = rd_hi; b_wr = wr_hi; b_rfw = rfw_hi;
    endtask

    task automatic do_alu(input logic [1:0] o, input logic [31:0] rz, input logic [31:0] pc,
                          input logic [4:0] rd, input logic we);
        stage_valid = 1; op = o; RZ = rz; PC_Temp = pc; RM = $urandom; Rdst_in = rd; wr_en_in = we;
        m.ry = (o == 2'b11) ? pc : rz; m.rdst = rd; m.rfw = we && (rd != 0); m.rdy = 0;
        tick();
        op = 2'b00; RZ = $urandom; Rdst_in = ~rd;   // offer during WB must be ignored
        m.rfw = 0; m.rdy = 1;
        tick();
        stage_valid = 0;
    endtask

    // k = edge index (1..) after capture at which MFC is raised; 0 = never
    task automatic do_mem(input logic ld, input logic [31:0] rz, input logic [31:0] rm,
                          input logic [4:0] rd, input logic we, input int k,
                          input logic [31:0] din, input logic clr_at_to);
        stage_valid = 1; op = ld ? 2'b01 : 2'b10; RZ = rz; RM = rm; Rdst_in = rd; wr_en_in = we;
        MEM_DATAIN = $urandom;
        m.rd = ld; m.wr = !ld; m.addr = rz; if (!ld) m.dout = rm;
        m.rdst = rd; m.rdy = 0; m.rfw = 0;
        tick();
        for (int i = 1; i <= TO; i++) begin
            op = 2'b00; RZ = $urandom; RM = $urandom; Rdst_in = $urandom;
            if (i == k) begin
                MFC = 1; MEM_DATAIN = din; m.rd = 0; m.wr = 0;
                if (ld) begin
                    m.ry = din; m.rfw = we && (rd != 0);
                    tick();
                    MFC = 0; m.rfw = 0; m.rdy = 1;
                    tick();
                end else begin
                    m.rdy = 1;
                    tick();
                end
                break;
            end else if (i == TO) begin
                m.rd = 0; m.wr = 0; m.err = 1; m.rdy = 1; err_clr = clr_at_to;
                tick();
                err_clr = 0;
                break;
            end else begin
                tick();
            end
        end
        stage_valid = 0; MFC = 0;
    endtask

    task automatic do_idle(input logic mfc);
        stage_valid = 0; MFC = mfc; m.rfw = 0; m.rdy = 1;
        tick();
        MFC = 0;
    endtask

    task automatic do_clr();
        err_clr = 1; m.err = 0; m.rfw = 0; m.rdy = 1;
        tick();
        err_clr = 0;
    endtask

    initial begin
        #2;
        chk("rst_ready",   32'(stage_ready), 32'd1);
        chk("rst_rd",      32'(MEM_READ),    32'd0);
        chk("rst_rfw",     32'(RF_WRITE),    32'd0);
        chk("rst_ry",      RY,               32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1;
        m_reset();

        base(); do_alu(2'b00, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        chk("alu_ry", RY, 32'h0000_1234);
        chk("alu_rdst", 32'(MuxC_Out_Rdst), 32'd5);
        chk("alu_rfw_cycles", rfw_hi - b_rfw, 1);

        do_alu(2'b11, 32'h0000_AAAA, 32'h4000_0010, 5'd31, 1'b1);
        chk("call_ry", RY, 32'h4000_0010);

        base(); do_mem(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 3, 32'hDEAD_BEEF, 1'b0);
        chk("load_rd_cycles", rd_hi - b_rd, 3);
        chk("load_ry", RY, 32'hDEAD_BEEF);
        chk("load_addr", MEM_ADDR, 32'h100);
        chk("load_rfw_cycles", rfw_hi - b_rfw, 1);

        base(); do_mem(1'b0, 32'h200, 32'h55, 5'd9, 1'b1, 2, 32'h0, 1'b0);
        chk("store_wr_cycles", wr_hi - b_wr, 2);
        chk("store_dout", MEM_DATAOUT, 32'h55);
        chk("store_rfw_cycles", rfw_hi - b_rfw, 0);

        do_idle(1'b1);
        do_mem(1'b1, 32'h180, 32'h0, 5'd12, 1'b1, 1, 32'h0BAD_F00D, 1'b0);

        base(); do_mem(1'b1, 32'h1C0, 32'h0, 5'd1, 1'b1, TO, 32'h1234_5678, 1'b0);
        chk("mfc_vs_to_err", 32'(MEM_ERR), 32'd0);
        chk("mfc_vs_to_rfw", rfw_hi - b_rfw, 1);

        base();
        do_alu(2'b00, 32'h0000_0042, 32'h0, 5'd0, 1'b1);
        do_alu(2'b00, 32'h0000_0043, 32'h0, 5'd6, 1'b0);
        chk("r0_noen_rfw_cycles", rfw_hi - b_rfw, 0);

        base(); do_mem(1'b1, 32'h400, 32'h0, 5'd8, 1'b1, 0, 32'h0, 1'b0);
        chk("to_rd_cycles", rd_hi - b_rd, 16);
        chk("to_err", 32'(MEM_ERR), 32'd1);
        chk("to_rfw_cycles", rfw_hi - b_rfw, 0);
        do_alu(2'b00, 32'h0000_0099, 32'h0, 5'd2, 1'b1);
        do_clr();
        chk("clr_err", 32'(MEM_ERR), 32'd0);

        do_mem(1'b0, 32'h500, 32'h66, 5'd3, 1'b0, 0, 32'h0, 1'b1);
        chk("clr_vs_to_err", 32'(MEM_ERR), 32'd1);
        do_clr();

        // reset during MEM_WAIT, then a late MFC
        stage_valid = 1; op = 2'b01; RZ = 32'h300; Rdst_in = 5'd4; wr_en_in = 1;
        m.rd = 1; m.addr = 32'h300; m.rdst = 4; m.rdy = 0;
        tick();
        stage_valid = 0;
        tick();
        reset_n = 0;
        #1;
        chk("rst_async_rd", 32'(MEM_READ), 32'd0);
        chk("rst_async_addr", MEM_ADDR, 32'd0);
        m_reset();
        exp_a[cyc] = m;
        base();
        MFC = 1;
        tick();
        reset_n = 1;
        do_alu(2'b00, 32'h0000_0077, 32'h0, 5'd3, 1'b1);
        do_idle(1'b1);
        chk("rst_rfw_cycles", rfw_hi - b_rfw, 1);
        chk("rst_ry", RY, 32'h0000_0077);

        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
